// File: rtl/morph_frame_sequencer.sv
// morph_frame_sequencer
// ---------------------
// Frame-level controller for the binarize -> erosion pixel pipeline.
// On start it reads one frame (IMAGE_WIDTH*IMAGE_HEIGHT grey pixels) from a
// source memory and streams it into the pipeline at one pixel per cycle. It
// writes the pipeline's results into a result memory, then waits a bounded
// number of cycles for the pipeline to drain. It finishes with a one-cycle
// done pulse, or an err_timeout pulse if fewer than N results arrived.
//
// Optional feature (compile-time macro PAD_FEED_EN):
//   defined   - during DRAIN, after the last real pixel, PAD_VALUE is fed
//               with pix_valid=1 every cycle to flush valid-driven pipelines.
//   undefined - pix_valid stays low in DRAIN after the last real pixel.
//
// Strobe semantics: every *_valid / *_en / done / err_timeout signal is a
// single-cycle qualifier with no back-pressure. A beat is transferred in
// every cycle where the strobe is high; there is no ready signal.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          one-cycle pulse, accepted only in IDLE
//   abort          synchronous cancel while in FETCH or DRAIN
//   busy           high in FETCH and DRAIN
//   done           one-cycle pulse, N results written
//   err_timeout    one-cycle pulse, drain timed out short of N results
//   res_count      results written this frame (held after the frame)
//   mem_rd_en      source read strobe
//   mem_addr       source read address
//   mem_rd_data    source data, valid one cycle after mem_rd_en
//   pix_valid      pixel strobe into the pipeline
//   pix_data       pixel into the pipeline
//   res_valid      result strobe from the pipeline
//   res_data       result pixel from the pipeline
//   out_wr_en      result memory write strobe
//   out_addr       result memory write address
//   out_data       result memory write data
//   dbg_state      current FSM state (0 IDLE, 1 FETCH, 2 DRAIN, 3 FINISH)
module morph_frame_sequencer #(
    parameter int IMAGE_WIDTH   = 320,
    parameter int IMAGE_HEIGHT  = 464,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 18,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int PAD_VALUE     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic [ADDR_WIDTH:0]   res_count,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            dbg_state
);

    localparam int N      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W  = $clog2(DRAIN_TIMEOUT) + 1;

    localparam logic [ADDR_WIDTH:0]   N_CNT      = (ADDR_WIDTH+1)'(N);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N - 1);
    localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] PAD_PIX    = DATA_WIDTH'(PAD_VALUE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   rd_idx, rd_idx_d;
    logic [ADDR_WIDTH:0]     res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0]        drain_cnt, drain_cnt_d;
    logic                    finish_ok, finish_ok_d;
    logic                    capture;
    logic                    real_q;   // pix_valid carries a fetched pixel
    logic                    pad_q;    // pix_valid carries a pad pixel
    logic                    pad_d;

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        // A result is accepted only while a frame is live, not aborting,
        // and the frame is not yet full; this is also what saturates
        // res_count at N.
        capture     = ((state == S_FETCH) || (state == S_DRAIN)) && !abort &&
                      res_valid && (res_cnt_q < N_CNT);
        state_d     = state;
        rd_idx_d    = rd_idx;
        res_cnt_d   = res_cnt_q + (ADDR_WIDTH+1)'(capture);
        drain_cnt_d = drain_cnt;
        finish_ok_d = finish_ok;
        pad_d       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    rd_idx_d    = '0;
                    res_cnt_d   = '0;
                    drain_cnt_d = '0;
                    finish_ok_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rd_idx == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_idx_d = rd_idx + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt != DRAIN_LAST) begin
                    drain_cnt_d = drain_cnt + CNT_W'(1);
                end
                // Completion looks at the count including this cycle's
                // capture, so the N-th result on the timeout boundary
                // still counts as done.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (res_cnt_d == N_CNT) begin
                    state_d     = S_FINISH;
                    finish_ok_d = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_d     = S_FINISH;
                    finish_ok_d = 1'b0;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PAD_FEED_EN
        // Pad pixels fill every DRAIN cycle after the first (which still
        // carries the last real pixel) for as long as DRAIN continues.
        pad_d = (state == S_DRAIN) && (state_d == S_DRAIN);
`else
        pad_d = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_idx    <= '0;
            res_cnt_q <= '0;
            drain_cnt <= '0;
            finish_ok <= 1'b0;
            real_q    <= 1'b0;
            pad_q     <= 1'b0;
            out_wr_en <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_d;
            rd_idx    <= rd_idx_d;
            res_cnt_q <= res_cnt_d;
            drain_cnt <= drain_cnt_d;
            finish_ok <= finish_ok_d;
            // A read issued in the abort cycle is dropped so that pix_valid
            // is low from the first IDLE cycle.
            real_q    <= (state == S_FETCH) && !abort;
            pad_q     <= pad_d;
            out_wr_en <= capture;
            if (capture) begin
                out_addr <= res_cnt_q[ADDR_WIDTH-1:0];
                out_data <= res_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_rd_en   = (state == S_FETCH);
    assign mem_addr    = (state == S_FETCH) ? rd_idx : '0;
    assign busy        = (state == S_FETCH) || (state == S_DRAIN);
    assign done        = (state == S_FINISH) && finish_ok;
    assign err_timeout = (state == S_FINISH) && !finish_ok;
    assign res_count   = res_cnt_q;
    assign pix_valid   = real_q || pad_q;
    // The source memory presents read data one cycle after the strobe,
    // which is exactly the cycle real_q is high, so the data passes
    // straight through alongside the registered valid.
    assign pix_data    = real_q ? mem_rd_data : (pad_q ? PAD_PIX : '0);
    assign dbg_state   = state;

endmodule

// File: tb/tb_morph_frame_sequencer.sv
// Directed testbench for morph_frame_sequencer with an 8x4 frame, a source
// memory holding its own address and a 10-cycle delay-line pipeline model.
module tb_morph_frame_sequencer;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int N   = W * H;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int TO  = 16;
    localparam int PAD = 255;
`ifdef PAD_FEED_EN
    localparam int EXP_PADS = 10;
`else
    localparam int EXP_PADS = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, err_timeout;
    logic [AW:0]   res_count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          out_wr_en;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg_state;

    morph_frame_sequencer #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .DRAIN_TIMEOUT(TO), .PAD_VALUE(PAD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .res_count(res_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .pix_valid(pix_valid), .pix_data(pix_data),
        .res_valid(res_valid), .res_data(res_data), .out_wr_en(out_wr_en),
        .out_addr(out_addr), .out_data(out_data), .dbg_state(dbg_state)
    );

    // ---------------- environment models ----------------
    // Source memory: word i holds i, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= DW'(mem_addr);
    end

    // Pipeline: 10-cycle delay line. emit_limit caps the results per frame;
    // once 32 have been emitted it keeps emitting filler results up to the
    // limit so that over-delivery can be exercised.
    logic [9:0]         pv = '0;
    logic [9:0][DW-1:0] pd = '0;
    int                 emitted = 0;
    int                 emit_limit = 0;
    logic               model_clr = 1'b0;

    always @(posedge clk) begin
        pv <= {pv[8:0], pix_valid};
        pd <= {pd[8:0], pix_data};
        if (model_clr) emitted <= 0;
        else if (res_valid) emitted <= emitted + 1;
    end
    assign res_valid = (emitted < emit_limit) && (pv[9] || emitted >= N);
    assign res_data  = pv[9] ? pd[9] : 8'hEE;

    // ---------------- recorder (samples on falling edge) ----------------
    int            cyc = 0;
    logic [DW-1:0] pix_q[$];
    int            pix_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            done_cnt = 0, err_cnt = 0;
    int            done_cyc = 0, err_cyc = 0, last_rd_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (pix_valid) begin
            pix_q.push_back(pix_data);
            pix_cyc_q.push_back(cyc);
        end
        if (out_wr_en) begin
            wr_addr_q.push_back(out_addr);
            wr_data_q.push_back(out_data);
        end
        if (done)        begin done_cnt++; done_cyc = cyc; end
        if (err_timeout) begin err_cnt++;  err_cyc  = cyc; end
        if (mem_rd_en)   last_rd_cyc = cyc;
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic new_frame(input int limit);
        emit_limit = limit;
        model_clr  = 1'b1;
        tick();
        model_clr  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int base_end, input string tag);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == base_end && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'((done_cnt + err_cnt) != base_end), 32'd1);
    endtask

    task automatic check_writes(input int base_wr, input int exp_n, input string tag);
        int n;
        logic [DW-1:0] e;
        n = wr_data_q.size() - base_wr;
        check({tag, "_wr_count"}, 32'(n), 32'(exp_n));
        exp_q.delete();
        for (int i = 0; i < exp_n; i++) exp_q.push_back(DW'(i));
        for (int i = 0; i < n && i < exp_n; i++) begin
            e = exp_q.pop_front();
            check({tag, "_wr_addr"}, 32'(wr_addr_q[base_wr + i]), 32'(i));
            check({tag, "_wr_data"}, 32'(wr_data_q[base_wr + i]), 32'(e));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_err"},       32'(err_timeout), 0);
        check({tag, "_res_count"}, 32'(res_count), 0);
        check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_mem_addr"},  32'(mem_addr), 0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 0);
        check({tag, "_pix_data"},  32'(pix_data), 0);
        check({tag, "_out_wr_en"}, 32'(out_wr_en), 0);
        check({tag, "_out_addr"},  32'(out_addr), 0);
        check({tag, "_out_data"},  32'(out_data), 0);
        check({tag, "_state"},     32'(dbg_state), 0);
    endtask

    // ---------------- directed sequence ----------------
    int base_pix, base_wr, base_done, base_err, n;

    initial begin
        // Reset state
        #2;
        check_outputs_zero("reset");
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        // 1: normal frame
        new_frame(N);
        base_pix = pix_q.size(); base_wr = wr_data_q.size();
        base_done = done_cnt; base_err = err_cnt;
        pulse_start();
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_state_fetch", 32'(dbg_state), 1);
        wait_end(base_done + base_err, "t1_end_seen");
        check("t1_done_pulses", 32'(done_cnt - base_done), 1);
        check("t1_err_pulses", 32'(err_cnt - base_err), 0);
        check("t1_done_latency", 32'(done_cyc - last_rd_cyc), 12);
        check("t1_pix_count", 32'(pix_q.size() - base_pix), 32'(N + EXP_PADS));
        for (int i = 0; i < N; i++)
            check("t1_pix_data", 32'(pix_q[base_pix + i]), 32'(i));
        check("t1_pix_gapless", 32'(pix_cyc_q[base_pix + N - 1] - pix_cyc_q[base_pix]), 32'(N - 1));
        for (int i = 0; i < EXP_PADS; i++)
            check("t1_pad_data", 32'(pix_q[base_pix + N + i]), 32'(PAD));
        check_writes(base_wr, N, "t1");
        check("t1_res_count", 32'(res_count), 32'(N));
        tick();
        check("t1_busy_low", 32'(busy), 0);
        check("t1_state_idle", 32'(dbg_state), 0);
        check("t1_done_single", 32'(done), 0);

        // 2: pipeline short by two results -> timeout
        ticks(15);
        new_frame(N - 2);
        base_wr = wr_data_q.size(); base_done = done_cnt; base_err = err_cnt;
        pulse_start();
        wait_end(base_done + base_err, "t2_end_seen");
        check("t2_err_pulses", 32'(err_cnt - base_err), 1);
        check("t2_done_pulses", 32'(done_cnt - base_done), 0);
        check("t2_err_latency", 32'(err_cyc - last_rd_cyc), 32'(TO + 1));
        check("t2_res_count", 32'(res_count), 32'(N - 2));
        check_writes(base_wr, N - 2, "t2");
        tick();
        check("t2_busy_low", 32'(busy), 0);

        // 3: pipeline over-delivers -> extra results discarded
        ticks(15);
        new_frame(N + 3);
        base_wr = wr_data_q.size(); base_done = done_cnt; base_err = err_cnt;
        pulse_start();
        wait_end(base_done + base_err, "t3_end_seen");
        ticks(10);
        check("t3_done_pulses", 32'(done_cnt - base_done), 1);
        check("t3_err_pulses", 32'(err_cnt - base_err), 0);
        check("t3_res_count", 32'(res_count), 32'(N));
        check_writes(base_wr, N, "t3");

        // 4: abort at read 12, then a clean frame
        ticks(15);
        new_frame(N);
        base_done = done_cnt; base_err = err_cnt;
        pulse_start();
        n = 0;
        while (!(mem_rd_en && mem_addr == AW'(12)) && n < 100) begin
            tick();
            n++;
        end
        check("t4_reached_read12", 32'(mem_rd_en && mem_addr == AW'(12)), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_mem_rd_en", 32'(mem_rd_en), 0);
        check("t4_pix_valid", 32'(pix_valid), 0);
        check("t4_out_wr_en", 32'(out_wr_en), 0);
        check("t4_state_idle", 32'(dbg_state), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_res_partial", 32'(res_count), 1);
        ticks(20);
        check("t4_no_pulse", 32'((done_cnt - base_done) + (err_cnt - base_err)), 0);
        check("t4_res_held", 32'(res_count), 1);
        // abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_idle_abort", 32'(dbg_state), 0);
        new_frame(N);
        base_wr = wr_data_q.size(); base_done = done_cnt; base_err = err_cnt;
        pulse_start();
        wait_end(base_done + base_err, "t4_restart_end");
        check("t4_restart_done", 32'(done_cnt - base_done), 1);
        check_writes(base_wr, N, "t4r");

        // 5: reset during DRAIN, then stray starts while busy
        ticks(15);
        new_frame(N);
        base_done = done_cnt; base_err = err_cnt;
        pulse_start();
        n = 0;
        while (dbg_state != 2'd2 && n < 100) begin
            tick();
            n++;
        end
        check("t5_reached_drain", 32'(dbg_state), 2);
        ticks(3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_async_reset");
        ticks(2);
        rst_n = 1'b1;
        ticks(20);
        check("t5_no_pulse", 32'((done_cnt - base_done) + (err_cnt - base_err)), 0);
        new_frame(N);
        base_wr = wr_data_q.size(); base_done = done_cnt; base_err = err_cnt;
        pulse_start();
        ticks(4);
        pulse_start();
        ticks(14);
        pulse_start();
        ticks(17);
        check("t5_state_drain", 32'(dbg_state), 2);
        pulse_start();
        wait_end(base_done + base_err, "t5_end_seen");
        ticks(60);
        check("t5_one_done", 32'(done_cnt - base_done), 1);
        check("t5_no_err", 32'(err_cnt - base_err), 0);
        check("t5_idle_after", 32'(busy), 0);
        check_writes(base_wr, N, "t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
